// File: rtl/sm83_pkg.sv
// Shared SM83 types: interrupt dispatch states, IRQ source indices and the
// IF/IE register addresses.
package sm83_pkg;

    typedef enum logic [2:0] {
        D_IDLE,
        D_WAIT1,
        D_WAIT2,
        D_PUSH_HI,
        D_PUSH_LO,
        D_JUMP
    } int_disp_state_t;

    typedef enum logic [2:0] {
        IRQ_VBLANK,
        IRQ_STAT,
        IRQ_TIMER,
        IRQ_SERIAL,
        IRQ_JOYPAD
    } irq_idx_t;

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    // Restart vector for an interrupt source index.
    function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                               input int        stride,
                                               input irq_idx_t  idx);
        return base + 16'(stride * int'(idx));
    endfunction

endpackage

// File: rtl/sm83_irq_prio.sv
// Lowest-set-bit priority encoder over pending interrupts; bit 0 (VBlank)
// has the highest priority. Also used by the core's HALT wake logic.
module sm83_irq_prio #(
    parameter int NUM_IRQ = 5
) (
    input  logic [NUM_IRQ-1:0] pending,
    output logic               valid,
    output logic [2:0]         idx
);

    always_comb begin
        valid = |pending;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one assigned.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/sm83_int_ctrl.sv
// SM83 interrupt controller: IF/IE/IME state, EI delay and the 5 M-cycle
// dispatch sequence (wait, wait, push PC hi, push PC lo, jump).
module sm83_int_ctrl
    import sm83_pkg::*;
#(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mcycle_tick,
    input  logic [NUM_IRQ-1:0] irq_pulse,
    input  logic               if_wr,
    input  logic               ie_wr,
    input  logic [7:0]         wdata,
    output logic [7:0]         if_rdata,
    output logic [7:0]         ie_rdata,
    input  logic               ei_i,
    input  logic               di_i,
    input  logic               reti_i,
    input  logic               instr_boundary,
    output logic               int_req,
    output logic               wake,
    output logic               busy,
    output logic               push_hi,
    output logic               push_lo,
    output logic               pc_load,
    output logic [15:0]        pc_vector,
    output logic               ime
);

    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_wr_val;
    logic [NUM_IRQ-1:0] if_clr;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pend_res;
    logic [7:0]         ie_q;
    logic [7:0]         ie_wr_val;
    logic               ime_q;
    logic [1:0]         ei_pend;
    logic               ime_eff;
    logic               take;
    logic               resolve;
    logic               res_valid;
    logic [2:0]         res_idx;

    int_disp_state_t state_q, state_d;

    assign pending = if_q & ie_q[NUM_IRQ-1:0];
    assign wake    = |pending;
    assign ime_eff = ime_q | (ei_pend == 2'd1);
    assign int_req = ime_eff & wake & (state_q == D_IDLE);
    assign take    = mcycle_tick & instr_boundary & int_req;
    assign resolve = mcycle_tick & (state_q == D_PUSH_HI);

    // Resolution sees this clk's register writes, so a PC-high push that
    // lands on IE can still cancel or redirect the dispatch.
    assign if_wr_val = if_wr ? wdata[NUM_IRQ-1:0] : if_q;
    assign ie_wr_val = ie_wr ? wdata : ie_q;
    assign pend_res  = if_wr_val & ie_wr_val[NUM_IRQ-1:0];

    sm83_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .pending (pend_res),
        .valid   (res_valid),
        .idx     (res_idx)
    );

    assign if_clr = (resolve && res_valid) ? (NUM_IRQ'(1) << res_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_q      <= '0;
            ie_q      <= '0;
            pc_vector <= 16'h0000;
        end else begin
            // Peripheral pulses are OR'd last so they beat writes and clears.
            if_q <= (if_wr_val & ~if_clr) | irq_pulse;
            if (ie_wr) ie_q <= wdata;
            if (resolve)
                pc_vector <= res_valid ? irq_vector(VEC_BASE, VEC_STRIDE, irq_idx_t'(res_idx))
                                       : 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ime_q   <= 1'b0;
            ei_pend <= 2'd0;
        end else begin
            if (instr_boundary && state_q == D_IDLE && ei_pend != 2'd0) begin
                ei_pend <= ei_pend - 2'd1;
                if (ei_pend == 2'd1) ime_q <= 1'b1;
            end
            if (ei_i && !ime_q) ei_pend <= 2'd2;
            if (reti_i) ime_q <= 1'b1;
            if (di_i || take) begin
                ime_q   <= 1'b0;
                ei_pend <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= D_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mcycle_tick) begin
            case (state_q)
                D_IDLE:    if (take) state_d = D_WAIT1;
                D_WAIT1:   state_d = D_WAIT2;
                D_WAIT2:   state_d = D_PUSH_HI;
                D_PUSH_HI: state_d = D_PUSH_LO;
                D_PUSH_LO: state_d = D_JUMP;
                D_JUMP:    state_d = D_IDLE;
                default:   state_d = D_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != D_IDLE);
    assign push_hi  = (state_q == D_PUSH_HI);
    assign push_lo  = (state_q == D_PUSH_LO);
    assign pc_load  = (state_q == D_JUMP);
    assign ime      = ime_q;
    assign if_rdata = {{(8 - NUM_IRQ){1'b1}}, if_q};
    assign ie_rdata = ie_q;

endmodule

// File: tb/tb_sm83_int_ctrl.sv
// Directed bench for sm83_int_ctrl: each task drives one scenario and checks
// against hand-computed values.
module tb_sm83_int_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mcycle_tick;
    logic [4:0]  irq_pulse;
    logic        if_wr, ie_wr;
    logic [7:0]  wdata;
    logic [7:0]  if_rdata, ie_rdata;
    logic        ei_i, di_i, reti_i;
    logic        instr_boundary;
    logic        int_req, wake, busy, push_hi, push_lo, pc_load, ime;
    logic [15:0] pc_vector;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm83_int_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mcycle_tick    (mcycle_tick),
        .irq_pulse      (irq_pulse),
        .if_wr          (if_wr),
        .ie_wr          (ie_wr),
        .wdata          (wdata),
        .if_rdata       (if_rdata),
        .ie_rdata       (ie_rdata),
        .ei_i           (ei_i),
        .di_i           (di_i),
        .reti_i         (reti_i),
        .instr_boundary (instr_boundary),
        .int_req        (int_req),
        .wake           (wake),
        .busy           (busy),
        .push_hi        (push_hi),
        .push_lo        (push_lo),
        .pc_load        (pc_load),
        .pc_vector      (pc_vector),
        .ime            (ime)
    );

    // Inputs change 1ns after a rising edge and are sampled at the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One M-cycle: three plain clks then the tick clk.
    task automatic mcyc(input bit bnd);
        repeat (3) step();
        mcycle_tick    = 1'b1;
        instr_boundary = bnd;
        step();
        mcycle_tick    = 1'b0;
        instr_boundary = 1'b0;
    endtask

    task automatic wr_ie(input logic [7:0] v);
        ie_wr = 1'b1; wdata = v; step(); ie_wr = 1'b0;
    endtask

    task automatic wr_if(input logic [7:0] v);
        if_wr = 1'b1; wdata = v; step(); if_wr = 1'b0;
    endtask

    task automatic do_reti();
        reti_i = 1'b1; step(); reti_i = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        chk("rst if_rdata", {8'h0, if_rdata}, 16'h00E0);
        chk("rst ie_rdata", {8'h0, ie_rdata}, 16'h0000);
        chk("rst strobes", {10'h0, int_req, busy, push_hi, push_lo, pc_load, ime}, 16'h0000);
        chk("rst pc_vector", pc_vector, 16'h0000);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_timer_dispatch();
        wr_ie(8'h04);
        do_reti();
        irq_pulse = 5'b00100; step(); irq_pulse = '0;
        chk("t1 if after pulse", {8'h0, if_rdata}, 16'h00E4);
        chk("t1 int_req", {15'h0, int_req}, 16'h0001);
        mcyc(1'b1);
        chk("t1 tick0 busy/ime", {14'h0, busy, ime}, 16'h0002);
        mcyc(1'b0);
        chk("t1 tick1 push_hi", {15'h0, push_hi}, 16'h0000);
        mcyc(1'b0);
        chk("t1 tick2 push_hi", {15'h0, push_hi}, 16'h0001);
        mcyc(1'b0);
        chk("t1 tick3 push_lo", {14'h0, push_hi, push_lo}, 16'h0001);
        chk("t1 pc_vector", pc_vector, 16'h0050);
        chk("t1 IF cleared", {8'h0, if_rdata}, 16'h00E0);
        mcyc(1'b0);
        chk("t1 tick4 pc_load", {15'h0, pc_load}, 16'h0001);
        mcyc(1'b0);
        chk("t1 tick5 idle", {13'h0, busy, pc_load, ime}, 16'h0000);
    endtask

    task automatic test_priority();
        wr_ie(8'h1F);
        wr_if(8'h1A);
        do_reti();
        chk("t2 int_req", {15'h0, int_req}, 16'h0001);
        mcyc(1'b1);
        repeat (3) mcyc(1'b0);
        chk("t2 pc_vector", pc_vector, 16'h0048);
        chk("t2 if_rdata", {8'h0, if_rdata}, 16'h00F8);
        repeat (2) mcyc(1'b0);
        chk("t2 idle busy", {15'h0, busy}, 16'h0000);
        chk("t2 wake no req", {14'h0, wake, int_req}, 16'h0002);
    endtask

    task automatic test_ei_delay();
        wr_ie(8'h01);
        wr_if(8'h01);
        ei_i = 1'b1; step(); ei_i = 1'b0;
        chk("t3 no req after ei", {15'h0, int_req}, 16'h0000);
        mcyc(1'b1);
        chk("t3 no dispatch 1st bnd", {15'h0, busy}, 16'h0000);
        chk("t3 req before 2nd bnd", {14'h0, int_req, ime}, 16'h0002);
        mcyc(1'b1);
        chk("t3 dispatch 2nd bnd", {14'h0, busy, ime}, 16'h0002);
        repeat (3) mcyc(1'b0);
        chk("t3 pc_vector", pc_vector, 16'h0040);
        repeat (2) mcyc(1'b0);
        wr_if(8'h01);
        ei_i = 1'b1; step(); ei_i = 1'b0;
        mcyc(1'b1);
        di_i = 1'b1; step(); di_i = 1'b0;
        chk("t3 di kills req", {15'h0, int_req}, 16'h0000);
        mcyc(1'b1);
        chk("t3 di no dispatch", {14'h0, busy, ime}, 16'h0000);
    endtask

    task automatic test_cancel();
        wr_ie(8'h04);
        wr_if(8'h04);
        do_reti();
        mcyc(1'b1);
        mcyc(1'b0);
        mcyc(1'b0);
        chk("t4 in push_hi", {15'h0, push_hi}, 16'h0001);
        repeat (3) step();
        mcycle_tick = 1'b1; ie_wr = 1'b1; wdata = 8'h00;
        step();
        mcycle_tick = 1'b0; ie_wr = 1'b0;
        chk("t4 cancel vector", pc_vector, 16'h0000);
        chk("t4 IF unchanged", {8'h0, if_rdata}, 16'h00E4);
        chk("t4 push_lo", {15'h0, push_lo}, 16'h0001);
        repeat (2) mcyc(1'b0);
        chk("t4 back to idle", {14'h0, busy, pc_load}, 16'h0000);
    endtask

    task automatic test_pulse_wins();
        wr_ie(8'h01);
        if_wr = 1'b1; wdata = 8'h00; irq_pulse = 5'b00001;
        step();
        if_wr = 1'b0; irq_pulse = '0;
        chk("t5 pulse beats write", {8'h0, if_rdata}, 16'h00E1);
        chk("t5 wake no ime", {13'h0, wake, int_req, ime}, 16'h0004);
    endtask

    task automatic test_async_reset();
        wr_ie(8'h04);
        wr_if(8'h04);
        do_reti();
        mcyc(1'b1);
        repeat (3) mcyc(1'b0);
        chk("t6 in push_lo", {15'h0, push_lo}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async strobes", {10'h0, int_req, busy, push_hi, push_lo, pc_load, ime}, 16'h0000);
        chk("t6 async regs", {if_rdata, ie_rdata}, 16'hE000);
        chk("t6 async vector/wake", {pc_vector[14:0], wake}, 16'h0000);
        #2 rst_n = 1'b1;
        repeat (3) mcyc(1'b1);
        chk("t6 quiet after reset", {11'h0, int_req, busy, push_hi, push_lo, pc_load}, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; mcycle_tick = 1'b0; irq_pulse = '0;
        if_wr = 1'b0; ie_wr = 1'b0; wdata = '0;
        ei_i = 1'b0; di_i = 1'b0; reti_i = 1'b0; instr_boundary = 1'b0;
        test_reset();
        test_timer_dispatch();
        test_priority();
        test_ei_delay();
        test_cancel();
        test_pulse_wins();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
